// File: rtl/swiglu_gate.sv
`default_nettype none
// ============================================================================
//  Module   : swiglu_gate
//  Purpose  : Streaming SwiGLU gate. Buffers silu(gate) and up-projection
//             elements in two small FIFOs, pairs them in arrival order,
//             multiplies each pair and emits the product on a registered
//             valid/ready output with a per-vector last flag.
//  Revision : 1.0 - initial release
// ============================================================================
module swiglu_gate #(
  parameter int I_EXP   = 8,
  parameter int I_MNT   = 23,
  parameter int I_DATA  = I_EXP + I_MNT + 1,
  parameter int DEPTH   = 4,
  parameter int VEC_LEN = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [I_DATA-1:0]        gate_data,
  input  logic                     gate_valid,
  output logic                     gate_ready,
  input  logic [I_DATA-1:0]        up_data,
  input  logic                     up_valid,
  output logic                     up_ready,
  output logic [I_DATA-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic [$clog2(DEPTH):0]   gate_level,
  output logic [$clog2(DEPTH):0]   up_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
  localparam int EW = I_EXP + 2;   // exponent arithmetic width with sign/carry room
  localparam int PW = 2 * I_MNT + 2;

  localparam logic [LW-1:0]    C_FULL_LVL = LW'(DEPTH);
  localparam logic [CW-1:0]    C_LAST_CNT = CW'(VEC_LEN - 1);
  localparam logic [EW-1:0]    C_BIAS     = EW'((1 << (I_EXP - 1)) - 1);
  localparam logic [EW-1:0]    C_EMAX     = EW'((1 << I_EXP) - 1);
  localparam logic [I_EXP-1:0] C_EXP_ONES = '1;

  // Float multiply: flush-to-zero on subnormal inputs, truncated mantissa,
  // overflow to infinity, NaN for NaN inputs or infinity times zero.
  function automatic logic [I_DATA-1:0] fmul(input logic [I_DATA-1:0] a,
                                             input logic [I_DATA-1:0] b);
    logic             so;
    logic [I_EXP-1:0] ea, eb;
    logic [I_MNT-1:0] ma, mb, mo;
    logic [PW-1:0]    prod;
    logic [EW-1:0]    esum;
    logic [I_DATA-1:0] r;
    so   = a[I_DATA-1] ^ b[I_DATA-1];
    ea   = a[I_DATA-2 -: I_EXP];
    eb   = b[I_DATA-2 -: I_EXP];
    ma   = a[I_MNT-1:0];
    mb   = b[I_MNT-1:0];
    prod = {{(I_MNT+1){1'b0}}, 1'b1, ma} * {{(I_MNT+1){1'b0}}, 1'b1, mb};
    esum = {2'b00, ea} + {2'b00, eb} - C_BIAS + {{(EW-1){1'b0}}, prod[PW-1]};
    mo   = prod[PW-1] ? prod[PW-2 -: I_MNT] : prod[PW-3 -: I_MNT];
    if ((ea == C_EXP_ONES && ma != '0) || (eb == C_EXP_ONES && mb != '0) ||
        (ea == C_EXP_ONES && eb == '0) || (eb == C_EXP_ONES && ea == '0)) begin
      r = {so, C_EXP_ONES, 1'b1, {(I_MNT-1){1'b0}}};
    end else if (ea == C_EXP_ONES || eb == C_EXP_ONES) begin
      r = {so, C_EXP_ONES, {I_MNT{1'b0}}};
    end else if (ea == '0 || eb == '0) begin
      r = {so, {(I_DATA-1){1'b0}}};
    end else if (esum[EW-1] || esum == '0) begin
      r = {so, {(I_DATA-1){1'b0}}};
    end else if (esum >= C_EMAX) begin
      r = {so, C_EXP_ONES, {I_MNT{1'b0}}};
    end else begin
      r = {so, esum[I_EXP-1:0], mo};
    end
    return r;
  endfunction

  logic [I_DATA-1:0] gate_mem_q [DEPTH];
  logic [I_DATA-1:0] gate_mem_d [DEPTH];
  logic [I_DATA-1:0] up_mem_q   [DEPTH];
  logic [I_DATA-1:0] up_mem_d   [DEPTH];
  logic [AW-1:0]     gate_wptr_q, gate_wptr_d, gate_rptr_q, gate_rptr_d;
  logic [AW-1:0]     up_wptr_q, up_wptr_d, up_rptr_q, up_rptr_d;
  logic [LW-1:0]     gate_lvl_q, gate_lvl_d, up_lvl_q, up_lvl_d;
  logic [CW-1:0]     count_q, count_d;
  logic [I_DATA-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;

  logic              gate_push, up_push, fire;
  logic [I_DATA-1:0] product;

  assign gate_ready = (gate_lvl_q != C_FULL_LVL);
  assign up_ready   = (up_lvl_q != C_FULL_LVL);
  assign gate_level = gate_lvl_q;
  assign up_level   = up_lvl_q;
  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign out_last   = out_last_q;

  assign gate_push = gate_valid && gate_ready;
  assign up_push   = up_valid && up_ready;
  assign fire      = (gate_lvl_q != '0) && (up_lvl_q != '0) && (!out_valid_q || out_ready);
  assign product   = fmul(gate_mem_q[gate_rptr_q], up_mem_q[up_rptr_q]);

  // Gate FIFO next state: write at tail on push, advance head on fire.
  always_comb begin
    gate_mem_d  = gate_mem_q;
    gate_wptr_d = gate_wptr_q;
    gate_rptr_d = gate_rptr_q;
    if (gate_push) begin
      gate_mem_d[gate_wptr_q] = gate_data;
      gate_wptr_d             = gate_wptr_q + 1'b1;
    end
    if (fire) begin
      gate_rptr_d = gate_rptr_q + 1'b1;
    end
    gate_lvl_d = gate_lvl_q + LW'(gate_push) - LW'(fire);
  end

  // Up FIFO next state: same structure as the gate FIFO.
  always_comb begin
    up_mem_d  = up_mem_q;
    up_wptr_d = up_wptr_q;
    up_rptr_d = up_rptr_q;
    if (up_push) begin
      up_mem_d[up_wptr_q] = up_data;
      up_wptr_d           = up_wptr_q + 1'b1;
    end
    if (fire) begin
      up_rptr_d = up_rptr_q + 1'b1;
    end
    up_lvl_d = up_lvl_q + LW'(up_push) - LW'(fire);
  end

  // Output register and vector position: load a product on fire, drop valid
  // once consumed with nothing new, otherwise hold.
  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    count_d     = count_q;
    if (fire) begin
      out_data_d  = product;
      out_valid_d = 1'b1;
      out_last_d  = (count_q == C_LAST_CNT);
      count_d     = (count_q == C_LAST_CNT) ? '0 : count_q + 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers, all cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        gate_mem_q[i] <= '0;
        up_mem_q[i]   <= '0;
      end
      gate_wptr_q <= '0;
      gate_rptr_q <= '0;
      gate_lvl_q  <= '0;
      up_wptr_q   <= '0;
      up_rptr_q   <= '0;
      up_lvl_q    <= '0;
      count_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      gate_mem_q  <= gate_mem_d;
      up_mem_q    <= up_mem_d;
      gate_wptr_q <= gate_wptr_d;
      gate_rptr_q <= gate_rptr_d;
      gate_lvl_q  <= gate_lvl_d;
      up_wptr_q   <= up_wptr_d;
      up_rptr_q   <= up_rptr_d;
      up_lvl_q    <= up_lvl_d;
      count_q     <= count_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_swiglu_gate.sv
`default_nettype none
// ============================================================================
//  Module   : tb_swiglu_gate
//  Purpose  : Directed scoreboard bench for swiglu_gate (DEPTH=4, VEC_LEN=4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_swiglu_gate;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int VL    = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] gate_data, up_data, out_data;
  logic          gate_valid, gate_ready, up_valid, up_ready;
  logic          out_valid, out_ready, out_last;
  logic [2:0]    gate_level, up_level;

  swiglu_gate #(.I_EXP(8), .I_MNT(23), .I_DATA(32), .DEPTH(DEPTH), .VEC_LEN(VL)) dut (
    .clk(clk), .rst(rst),
    .gate_data(gate_data), .gate_valid(gate_valid), .gate_ready(gate_ready),
    .up_data(up_data), .up_valid(up_valid), .up_ready(up_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .gate_level(gate_level), .up_level(up_level)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [DW-1:0] d; logic l; } exp_t;
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   vcount = 0;

  // gate, up, hand-computed product
  logic [DW-1:0] tg [10];
  logic [DW-1:0] tu [10];
  logic [DW-1:0] tp [10];

  function automatic void chk(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void timeout(string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out at %0t", nm, $time);
  endfunction

  function automatic void expect_prod(logic [DW-1:0] p);
    sb.push_back({p, (vcount == VL-1)});
    vcount = (vcount == VL-1) ? 0 : vcount + 1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_pair(input logic [DW-1:0] g, input logic [DW-1:0] u);
    int   t = 0;
    logic g_ok, u_ok;
    gate_data = g; up_data = u; gate_valid = 1'b1; up_valid = 1'b1;
    while ((gate_valid || up_valid) && t < 200) begin
      g_ok = gate_ready;
      u_ok = up_ready;
      step();
      if (g_ok) gate_valid = 1'b0;
      if (u_ok) up_valid = 1'b0;
      t++;
    end
    if (gate_valid || up_valid) begin
      timeout("push_pair");
      gate_valid = 1'b0; up_valid = 1'b0;
    end
  endtask

  task automatic push_one(input logic is_gate, input logic [DW-1:0] v);
    int   t = 0;
    logic ok;
    ok = 1'b0;
    if (is_gate) begin gate_data = v; gate_valid = 1'b1; end
    else begin up_data = v; up_valid = 1'b1; end
    while (!ok && t < 200) begin
      ok = is_gate ? gate_ready : up_ready;
      step();
      t++;
    end
    gate_valid = 1'b0; up_valid = 1'b0;
    if (!ok) timeout("push_one");
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 200) begin
      step();
      t++;
    end
    if (sb.size() != 0) timeout("drain");
  endtask

  // Monitor: score every handshake against the queue, and check that a
  // stalled output holds its data and last flag.
  logic          held;
  logic [DW-1:0] held_d;
  logic          held_l;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      held = 1'b0;
    end else if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_output: got %h with empty queue at %0t", out_data, $time);
      end else begin
        e = sb.pop_front();
        chk("out_data", out_data, e.d);
        chk("out_last", {31'd0, out_last}, {31'd0, e.l});
      end
      held = 1'b0;
    end else if (out_valid) begin
      if (held) begin
        chk("stall_data", out_data, held_d);
        chk("stall_last", {31'd0, out_last}, {31'd0, held_l});
      end
      held = 1'b1; held_d = out_data; held_l = out_last;
    end else begin
      held = 1'b0;
    end
  end

  initial begin
    tg[0] = 32'h40000000; tu[0] = 32'h40400000; tp[0] = 32'h40C00000; //  2.0 *  3.0 =  6.0
    tg[1] = 32'h00000000; tu[1] = 32'hC0A00000; tp[1] = 32'h80000000; //  0.0 * -5.0 = -0.0
    tg[2] = 32'h3F800000; tu[2] = 32'h3F800000; tp[2] = 32'h3F800000; //  1.0 *  1.0 =  1.0
    tg[3] = 32'h3FC00000; tu[3] = 32'h40000000; tp[3] = 32'h40400000; //  1.5 *  2.0 =  3.0
    tg[4] = 32'hC0000000; tu[4] = 32'h3F000000; tp[4] = 32'hBF800000; // -2.0 *  0.5 = -1.0
    tg[5] = 32'h40800000; tu[5] = 32'h40800000; tp[5] = 32'h41800000; //  4.0 *  4.0 = 16.0
    tg[6] = 32'h3FC00000; tu[6] = 32'h3FC00000; tp[6] = 32'h40100000; //  1.5 *  1.5 = 2.25
    tg[7] = 32'h40400000; tu[7] = 32'hC0400000; tp[7] = 32'hC1100000; //  3.0 * -3.0 = -9.0
    tg[8] = 32'h3FA00000; tu[8] = 32'h40800000; tp[8] = 32'h40A00000; // 1.25 *  4.0 =  5.0
    tg[9] = 32'h42C80000; tu[9] = 32'h40000000; tp[9] = 32'h43480000; //  100 *  2.0 =  200

    rst = 1'b1; gate_valid = 1'b0; up_valid = 1'b0; out_ready = 1'b1;
    gate_data = '0; up_data = '0;
    step(); step();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_last", {31'd0, out_last}, 32'd0);
    chk("rst_gate_level", {29'd0, gate_level}, 32'd0);
    chk("rst_up_level", {29'd0, up_level}, 32'd0);
    chk("rst_readies", {30'd0, gate_ready, up_ready}, 32'd3);
    rst = 1'b0;
    step();

    // Basic product and latency
    expect_prod(tp[0]);
    push_pair(tg[0], tu[0]);
    chk("lat_valid_early", {31'd0, out_valid}, 32'd0);
    step();
    chk("lat_valid", {31'd0, out_valid}, 32'd1);
    chk("lat_data", out_data, 32'h40C00000);
    drain();

    // Saturated gate
    expect_prod(tp[1]);
    push_pair(tg[1], tu[1]);
    drain();

    // Backpressure: one product held, four pairs queued, sixth stalls
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      expect_prod(tp[i]);
      push_pair(tg[i], tu[i]);
    end
    chk("bp_gate_level", {29'd0, gate_level}, 32'd4);
    chk("bp_up_level", {29'd0, up_level}, 32'd4);
    chk("bp_readies", {30'd0, gate_ready, up_ready}, 32'd0);
    chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
    gate_data = tg[5]; up_data = tu[5]; gate_valid = 1'b1; up_valid = 1'b1;
    step(); step(); step();
    chk("bp_stall_level", {29'd0, gate_level}, 32'd4);
    expect_prod(tp[5]);
    out_ready = 1'b1;
    push_pair(tg[5], tu[5]);
    drain();

    // Unbalanced streams
    for (int i = 0; i < 3; i++) push_one(1'b1, tg[6+i]);
    step(); step();
    chk("unbal_out_valid", {31'd0, out_valid}, 32'd0);
    chk("unbal_gate_level", {29'd0, gate_level}, 32'd3);
    for (int i = 0; i < 3; i++) begin
      expect_prod(tp[6+i]);
      push_one(1'b0, tu[6+i]);
    end
    drain();

    // Reset mid-stream
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      expect_prod(tp[i]);
      push_pair(tg[i], tu[i]);
    end
    #2 rst = 1'b1;
    #1;
    chk("mrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mrst_levels", {26'd0, gate_level, up_level}, 32'd0);
    chk("mrst_out_last", {31'd0, out_last}, 32'd0);
    sb.delete();
    vcount = 0;
    out_ready = 1'b1;
    #3 rst = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      expect_prod(tp[6+i]);
      push_pair(tg[6+i], tu[6+i]);
    end
    drain();

    // Vector framing: nine pairs back to back, last on products 4 and 8
    for (int i = 0; i < 9; i++) begin
      expect_prod(tp[i]);
      push_pair(tg[i], tu[i]);
    end
    drain();
    step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got %0d compared", n_cmp);
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/swiglu_gate.md
Name: swiglu_gate

Overview:
Streaming SwiGLU gating stage that sits directly downstream of the silu activation in the vector engine. It consumes silu(gate) elements and the matching up-projection elements on two independent valid/ready streams. It buffers each stream in a small FIFO, pairs the elements in arrival order, and multiplies each pair with the codebase fmul. The product is emitted on a registered valid/ready output, with a per-vector last flag.

Parameters:
I_EXP, 8, exponent width of the float format
I_MNT, 23, mantissa width
I_DATA, I_EXP+I_MNT+1, element width
DEPTH, 4, entries per input FIFO (power of two, >=2)
VEC_LEN, 16, elements per vector; sets the out_last cadence (>=1)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
gate_data  in  I_DATA  silu output element
gate_valid  in  1  gate element present
gate_ready  out  1  gate FIFO not full
up_data  in  I_DATA  up-projection element
up_valid  in  1  up element present
up_ready  out  1  up FIFO not full
out_data  out  I_DATA  gate*up product
out_valid  out  1  output holds a product
out_ready  in  1  downstream accepts
out_last  out  1  product is the last element of a vector
gate_level  out  clog2(DEPTH)+1  gate FIFO occupancy
up_level  out  clog2(DEPTH)+1  up FIFO occupancy

Behaviour:
- One clock: clk. Reset rst is asynchronous and active-high. All state is cleared on assertion of rst, independent of clk.
- Reset values:
  - Both FIFOs are empty, with pointers and levels at 0.
  - out_valid=0, out_data=0, out_last=0.
  - Element counter = 0.
- Ready signals: gate_ready = (gate_level != DEPTH) and up_ready = (up_level != DEPTH). Both are combinational from registered level only.
  - Inputs are never bypassed to the output.
  - A push on a full FIFO cannot occur.
- Push rule: a push happens when x_valid && x_ready at a clk edge, with rst low. The data is written at the write pointer and the write pointer wraps modulo DEPTH.
- Fire condition: fire = (gate_level!=0) && (up_level!=0) && (!out_valid || out_ready).
- On fire, in the same edge:
  - Both FIFO heads are popped.
  - out_data <= fmul(gate_head, up_head).
  - out_valid <= 1.
  - out_last <= (count == VEC_LEN-1).
  - count <= (count == VEC_LEN-1) ? 0 : count+1.
- If out_valid && out_ready && !fire, then out_valid <= 0. out_data and out_last hold their values.
- While out_valid && !out_ready, out_data and out_last are stable.
- Simultaneous push and pop on the same FIFO in one cycle leaves the level unchanged. This is legal at any level below DEPTH, including level 1 (pop the old head, write the new tail).
- Latency: an element accepted at edge T is at the FIFO head after T. The earliest fire is at edge T+1, so out_valid is high after edge T+1. Sustained throughput is one product per cycle when both streams are valid and out_ready=1.
- Unbalanced streams: pairing is strictly by arrival order per stream.
  - Surplus elements wait in their own FIFO.
  - No element is dropped or reordered.
- Arithmetic is fmul semantics unchanged. A gate of zero (silu saturated for x<-4) yields a zero product, with the sign from the XOR of the operand signs. There is no rounding or special-value handling beyond fmul.
- fmul is combinational between the FIFO head registers and the output register. It adds no extra pipeline stage.
- Reset mid-operation discards:
  - all FIFO contents;
  - a pending output;
  - a partial vector count.
  The first product after reset is element 0 of a new vector.
- Counter: width is clog2(VEC_LEN) with a minimum of 1. When VEC_LEN=1, out_last=1 on every product.

Test Plan:
- Basic product, VEC_LEN=4: push gate 0x40000000 (2.0) and up 0x40400000 (3.0) in one cycle with out_ready=1. Required: out_valid=1 exactly 2 edges after the push, out_data=0x40C00000 (6.0), out_last=0.
- Saturated gate: gate=0x00000000, up=0xC0A00000 (-5.0). Required: out_data magnitude 0, no X/NaN.
- Backpressure, DEPTH=4: out_ready=0, push 6 element pairs.
  - Required: one product is held in the output register and 4 pairs sit in the FIFOs (levels=4, gate_ready=up_ready=0).
  - Required: the 6th push stalls.
  - On out_ready=1, all 6 products emerge in order, 1/cycle, with out_data stable while stalled.
- Unbalanced streams: push 3 gate elements with up_valid=0.
  - Required: out_valid stays 0 and gate_level=3.
  - Then push 3 up elements. Required: 3 products in gate/up arrival order.
- Vector framing, VEC_LEN=4: stream 9 pairs continuously. Required: out_last=1 on products 4 and 8 only, and the counter wraps.
- Reset mid-stream: assert rst asynchronously (between edges) with FIFOs partly full and out_valid=1.
  - Required: out_valid=0, levels=0 and out_last=0 immediately.
  - After release, a new 4-pair stream gives out_last on the 4th product.
